// File: rtl/mem_model_l2_backing.sv
// Main-memory responder for the L2<->MEM interface: stores written-back lines, returns an
// address-derived fill for never-written lines, with programmable latency and request counters.
module mem_model_l2_backing #(
   parameter int LINE_W  = 512,
   parameter int INDEX_W = 8,
   parameter int TAG_W   = 18,
   parameter int DEPTH_W = 10,
   parameter int RD_LAT  = 4,
   parameter int WR_LAT  = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               read_L2_MEM,
   input  logic               write_L2_MEM,
   input  logic [INDEX_W-1:0] index_L2_MEM,
   input  logic [TAG_W-1:0]   tag_L2_MEM,
   input  logic [TAG_W-1:0]   write_tag_L2_MEM,
   input  logic [LINE_W-1:0]  write_data_L2_MEM,
   output logic               ready_MEM_L2,
   output logic [LINE_W-1:0]  read_data_MEM_L2,
   output logic               busy,
   output logic [CNT_W-1:0]   rd_cnt,
   output logic [CNT_W-1:0]   wr_cnt
);

   localparam int NLINES  = 1 << DEPTH_W;
   localparam int ADDR_W  = TAG_W + INDEX_W;
   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int LAT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RESP,
      S_GAP
   } state_t;

   state_t              state_q;
   logic [LAT_W-1:0]    cnt_q;
   logic                pend_rd_q;
   logic                did_rd_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic [DEPTH_W-1:0]  wr_slot_q;
   logic [LINE_W-1:0]   wr_data_q;
   logic [LINE_W-1:0]   rdata_q;
   logic                ready_q;
   logic [CNT_W-1:0]    rd_cnt_q;
   logic [CNT_W-1:0]    wr_cnt_q;
   logic [NLINES-1:0]   valid_q;
   logic [LINE_W-1:0]   mem_q [NLINES];

   logic [ADDR_W-1:0]   wr_addr;
   logic [ADDR_W-1:0]   req_addr;
   logic [DEPTH_W-1:0]  rd_slot;
   logic                lat_done;
   logic                commit;
   logic [ADDR_W+5:0]   fill_addr;
   logic [31:0]         fill_word;
   logic [LINE_W-1:0]   rd_line_d;
   logic                unused_wr_hi;

   assign wr_addr      = {write_tag_L2_MEM, index_L2_MEM};
   assign req_addr     = {tag_L2_MEM, index_L2_MEM};
   assign rd_slot      = rd_addr_q[DEPTH_W-1:0];
   assign lat_done     = (cnt_q == LAT_W'(1));
   assign commit       = (state_q == S_WRITE) && lat_done;
   // Only the slot bits of the write address matter; the upper bits alias freely.
   assign unused_wr_hi = ^wr_addr;

   assign fill_addr = {rd_addr_q, 6'b0};
   assign fill_word = 32'(fill_addr);

   always_comb begin
      rd_line_d = {(LINE_W/32){fill_word}};
      if (valid_q[rd_slot]) begin
         rd_line_d = mem_q[rd_slot];
      end
   end

   // Line storage has no reset; the valid bits decide whether a slot counts as written.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem_q[wr_slot_q] <= wr_data_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pend_rd_q <= 1'b0;
         did_rd_q  <= 1'b0;
         rd_addr_q <= '0;
         wr_slot_q <= '0;
         wr_data_q <= '0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         valid_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               did_rd_q <= 1'b0;
               if (write_L2_MEM) begin
                  state_q   <= S_WRITE;
                  cnt_q     <= LAT_W'(WR_LAT);
                  wr_slot_q <= wr_addr[DEPTH_W-1:0];
                  wr_data_q <= write_data_L2_MEM;
                  pend_rd_q <= read_L2_MEM;
                  rd_addr_q <= req_addr;
               end else if (read_L2_MEM) begin
                  state_q   <= S_READ;
                  cnt_q     <= LAT_W'(RD_LAT);
                  pend_rd_q <= 1'b0;
                  rd_addr_q <= req_addr;
               end
            end
            S_WRITE: begin
               if (lat_done) begin
                  valid_q[wr_slot_q] <= 1'b1;
                  wr_cnt_q           <= wr_cnt_q + 1'b1;
                  if (pend_rd_q) begin
                     state_q <= S_READ;
                     cnt_q   <= LAT_W'(RD_LAT);
                  end else begin
                     state_q <= S_RESP;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_READ: begin
               if (lat_done) begin
                  rdata_q  <= rd_line_d;
                  did_rd_q <= 1'b1;
                  state_q  <= S_RESP;
                  ready_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (did_rd_q) begin
                  rd_cnt_q <= rd_cnt_q + 1'b1;
               end
               state_q <= S_GAP;
            end
            S_GAP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ready_MEM_L2     = ready_q;
   assign read_data_MEM_L2 = rdata_q;
   assign busy             = (state_q != S_IDLE);
   assign rd_cnt           = rd_cnt_q;
   assign wr_cnt           = wr_cnt_q;

endmodule

// File: tb/tb_mem_model_l2_backing.sv
// Randomized bench for mem_model_l2_backing: a slot-keyed line store plus a per-transaction
// timing window predict ready, busy, read data and counters on every cycle.
module tb_mem_model_l2_backing;

   localparam int LINE_W  = 512;
   localparam int INDEX_W = 8;
   localparam int TAG_W   = 18;
   localparam int DEPTH_W = 10;
   localparam int RD_LAT  = 4;
   localparam int WR_LAT  = 4;
   localparam int CNT_W   = 16;
   localparam int NW      = LINE_W / 32;

   logic               clk;
   logic               rst;
   logic               read_L2_MEM;
   logic               write_L2_MEM;
   logic [INDEX_W-1:0] index_L2_MEM;
   logic [TAG_W-1:0]   tag_L2_MEM;
   logic [TAG_W-1:0]   write_tag_L2_MEM;
   logic [LINE_W-1:0]  write_data_L2_MEM;
   logic               ready_MEM_L2;
   logic [LINE_W-1:0]  read_data_MEM_L2;
   logic               busy;
   logic [CNT_W-1:0]   rd_cnt;
   logic [CNT_W-1:0]   wr_cnt;

   mem_model_l2_backing #(
      .LINE_W(LINE_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .DEPTH_W(DEPTH_W),
      .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .read_L2_MEM(read_L2_MEM),
      .write_L2_MEM(write_L2_MEM),
      .index_L2_MEM(index_L2_MEM),
      .tag_L2_MEM(tag_L2_MEM),
      .write_tag_L2_MEM(write_tag_L2_MEM),
      .write_data_L2_MEM(write_data_L2_MEM),
      .ready_MEM_L2(ready_MEM_L2),
      .read_data_MEM_L2(read_data_MEM_L2),
      .busy(busy),
      .rd_cnt(rd_cnt),
      .wr_cnt(wr_cnt)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- model state ----------------
   logic [LINE_W-1:0] store [int];
   logic [CNT_W-1:0]  exp_rd_cnt = '0;
   logic [CNT_W-1:0]  exp_wr_cnt = '0;
   bit                txn_active = 1'b0;
   bit                txn_rd = 1'b0;
   int                txn_k = 0;
   int                txn_lat = 0;
   logic [LINE_W-1:0] exp_line = '0;

   logic [LINE_W-1:0] last_data = '0;
   int                last_ready_cyc = 0;
   int                n_ready = 0;

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic int slot_of(input int tag, input int idx);
      return (tag * 256 + idx) % (1 << DEPTH_W);
   endfunction

   function automatic logic [LINE_W-1:0] addr_line(input int tag, input int idx);
      logic [LINE_W-1:0] l;
      logic [31:0]       w;
      w = 32'((tag * 256 + idx) * 64);
      for (int i = 0; i < NW; i++) l[i*32 +: 32] = w;
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] model_read(input int tag, input int idx);
      int s;
      s = slot_of(tag, idx);
      if (store.exists(s)) return store[s];
      return addr_line(tag, idx);
   endfunction

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < NW; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bit in_txn;
      bit exp_rdy;
      in_txn  = !rst && txn_active && (cyc >= txn_k) && (cyc <= txn_k + txn_lat + 1);
      exp_rdy = !rst && txn_active && (cyc == txn_k + txn_lat);
      check("busy", LINE_W'(busy), LINE_W'(in_txn));
      check("ready", LINE_W'(ready_MEM_L2), LINE_W'(exp_rdy));
      if (ready_MEM_L2) begin
         last_data      = read_data_MEM_L2;
         last_ready_cyc = cyc;
         n_ready++;
      end
      if (exp_rdy && txn_rd) check("rdata", read_data_MEM_L2, exp_line);
      if (!in_txn) begin
         check("rd_cnt", LINE_W'(rd_cnt), LINE_W'(exp_rd_cnt));
         check("wr_cnt", LINE_W'(wr_cnt), LINE_W'(exp_wr_cnt));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_until(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scramble_inputs();
      read_L2_MEM       = 1'b0;
      write_L2_MEM      = 1'b0;
      index_L2_MEM      = INDEX_W'($urandom);
      tag_L2_MEM        = TAG_W'($urandom);
      write_tag_L2_MEM  = TAG_W'($urandom);
      write_data_L2_MEM = rand_line();
   endtask

   // Called just after a rising edge with the DUT idle; accept happens on the next edge.
   task automatic do_txn(input bit rd, input bit wr, input int tag, input int wtag,
                         input int idx, input logic [LINE_W-1:0] data, input int hold,
                         output int k);
      read_L2_MEM       = rd;
      write_L2_MEM      = wr;
      tag_L2_MEM        = TAG_W'(tag);
      write_tag_L2_MEM  = TAG_W'(wtag);
      index_L2_MEM      = INDEX_W'(idx);
      write_data_L2_MEM = data;
      k = cyc + 1;
      if (wr) store[slot_of(wtag, idx)] = data;
      txn_rd     = rd;
      exp_line   = rd ? model_read(tag, idx) : '0;
      txn_lat    = (wr ? WR_LAT : 0) + (rd ? RD_LAT : 0);
      txn_k      = k;
      txn_active = 1'b1;
      wait_until(k + txn_lat + hold);
      scramble_inputs();
      wait_until(k + txn_lat + 2);
      if (rd) exp_rd_cnt = exp_rd_cnt + 1'b1;
      if (wr) exp_wr_cnt = exp_wr_cnt + 1'b1;
      txn_active = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int r0;
      logic [LINE_W-1:0] d;

      rst = 1'b1;
      scramble_inputs();
      @(posedge clk);
      #1;
      check("rst_ready", LINE_W'(ready_MEM_L2), '0);
      check("rst_data", read_data_MEM_L2, '0);
      check("rst_busy", LINE_W'(busy), '0);
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(1);

      // read of a never-written line
      do_txn(1'b1, 1'b0, 1, 0, 8'h05, '0, 0, k);
      check("t1_lat", LINE_W'(last_ready_cyc - k), LINE_W'(4));
      check("t1_word0", LINE_W'(last_data[31:0]), LINE_W'(32'h0000_4140));
      check("t1_wordN", LINE_W'(last_data[LINE_W-1 -: 32]), LINE_W'(32'h0000_4140));
      check("t1_rd_cnt", LINE_W'(rd_cnt), LINE_W'(1));
      check("t1_wr_cnt", LINE_W'(wr_cnt), LINE_W'(0));

      // write-only, then read back
      r0 = n_ready;
      do_txn(1'b0, 1'b1, 0, 2, 8'h10, {NW{32'hDEAD_BEEF}}, 0, k);
      check("t2_lat", LINE_W'(last_ready_cyc - k), LINE_W'(4));
      check("t2_wr_cnt", LINE_W'(wr_cnt), LINE_W'(1));
      do_txn(1'b1, 1'b0, 2, 0, 8'h10, '0, 0, k);
      check("t2_data", last_data, {NW{32'hDEAD_BEEF}});

      // combined, different tags
      do_txn(1'b1, 1'b1, 4, 3, 8'h22, {NW{32'h1234_5678}}, 0, k);
      check("t3_lat", LINE_W'(last_ready_cyc - k), LINE_W'(8));
      check("t3_data", last_data, {NW{32'h0001_0880}});
      do_txn(1'b1, 1'b0, 3, 0, 8'h22, '0, 1, k);
      check("t3_readback", last_data, {NW{32'h1234_5678}});

      // combined, same tag: write commits before the read
      d = rand_line();
      do_txn(1'b1, 1'b1, 5, 5, 8'h01, d, 0, k);
      check("t4_raw", last_data, d);

      // request held through RESP and GAP
      r0 = n_ready;
      do_txn(1'b1, 1'b0, 7, 0, 8'h33, '0, 2, k);
      idle_cycles(3);
      check("t5_one_ready", LINE_W'(n_ready - r0), LINE_W'(1));

      // reset two cycles into a write
      d = rand_line();
      read_L2_MEM       = 1'b0;
      write_L2_MEM      = 1'b1;
      write_tag_L2_MEM  = TAG_W'(2);
      index_L2_MEM      = INDEX_W'(8'h77);
      write_data_L2_MEM = d;
      k = cyc + 1;
      txn_rd     = 1'b0;
      txn_lat    = WR_LAT;
      txn_k      = k;
      txn_active = 1'b1;
      wait_until(k + 2);
      rst = 1'b1;
      store.delete();
      exp_rd_cnt = '0;
      exp_wr_cnt = '0;
      txn_active = 1'b0;
      #1;
      check("t6_busy", LINE_W'(busy), '0);
      check("t6_ready", LINE_W'(ready_MEM_L2), '0);
      check("t6_data", read_data_MEM_L2, '0);
      check("t6_rd_cnt", LINE_W'(rd_cnt), '0);
      check("t6_wr_cnt", LINE_W'(wr_cnt), '0);
      scramble_inputs();
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(1);
      do_txn(1'b1, 1'b0, 2, 0, 8'h77, '0, 0, k);
      check("t6_fill", last_data, {NW{32'h0000_9DC0}});

      // randomized traffic, addresses kept inside the stored range
      for (int i = 0; i < 200; i++) begin
         int mode;
         int tg;
         int wtg;
         int ix;
         mode = $urandom_range(0, 2);
         tg   = $urandom_range(0, 3);
         ix   = $urandom_range(0, 255);
         wtg  = ($urandom_range(0, 2) == 0) ? tg : $urandom_range(0, 3);
         do_txn(mode != 1, mode != 0, tg, wtg, ix, rand_line(),
                $urandom_range(0, 2), k);
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
